writeback_bypass: RTL and testbench

Parametrised successor to the existing writeback stage. It registers the result leaving the memory stage and drives the register-file write port (`rdOut`, `regWriteEnable`, `writeBackData`). It aligns and sign/zero-extends sub-word loads. It keeps a short history of retired writes so decode can forward results that have not yet reached the register file.

---
 rtl/writeback_bypass_pkg.sv | 19 +
 rtl/writeback_bypass_load_aligner.sv | 43 ++++
 rtl/writeback_bypass.sv | 144 ++++++++++++++
 tb/tb_writeback_bypass.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_bypass_pkg.sv
// Shared control encodings for the writeback stage: load-size codes and the
// bit layout of the packed control word presented by the memory stage.
package writeback_bypass_pkg;

  typedef enum logic [1:0] {
    LS_WORD     = 2'b00,
    LS_HALF     = 2'b01,
    LS_BYTE     = 2'b10,
    LS_WORD_ALT = 2'b11
  } load_size_e;

  localparam int CONTROL_REG_SIZE   = 6;
  localparam int CTRL_VALID         = 0;
  localparam int CTRL_REG_WRITE     = 1;
  localparam int CTRL_MEM_TO_REG    = 2;
  localparam int CTRL_LOAD_UNSIGNED = 3;
  localparam int CTRL_SIZE_LSB      = 4;

endpackage

// File: rtl/writeback_bypass_load_aligner.sv
// Big-endian sub-word load extraction with sign/zero extension.
// Offset 0 addresses the most significant byte of the memory word.
module load_aligner
  import writeback_bypass_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [1:0]            byte_offset,
  output logic [DATA_WIDTH-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_fill;
  logic        half_fill;

  always_comb begin
    case (byte_offset)
      2'd0:    byte_sel = mem_data[DATA_WIDTH-1  -: 8];
      2'd1:    byte_sel = mem_data[DATA_WIDTH-9  -: 8];
      2'd2:    byte_sel = mem_data[DATA_WIDTH-17 -: 8];
      default: byte_sel = mem_data[DATA_WIDTH-25 -: 8];
    endcase

    // offset bit 0 is irrelevant for halves
    half_sel = byte_offset[1] ? mem_data[DATA_WIDTH-17 -: 16]
                              : mem_data[DATA_WIDTH-1  -: 16];

    byte_fill = ~load_unsigned & byte_sel[7];
    half_fill = ~load_unsigned & half_sel[15];

    ext_data = mem_data;
    case (load_size_e'(load_size))
      LS_BYTE: ext_data = {{(DATA_WIDTH-8){byte_fill}}, byte_sel};
      LS_HALF: ext_data = {{(DATA_WIDTH-16){half_fill}}, half_sel};
      default: ext_data = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_bypass.sv
// Writeback stage: registers the retiring result onto the register-file write
// port and keeps a short per-cycle history of writes for decode forwarding.
module writeback_bypass
  import writeback_bypass_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int HISTORY_DEPTH  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      in_valid,
  input  logic                      in_reg_write,
  input  logic                      in_mem_to_reg,
  input  logic [1:0]                in_load_size,
  input  logic                      in_load_unsigned,
  input  logic [1:0]                in_byte_offset,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]     in_alu_data,
  input  logic [DATA_WIDTH-1:0]     in_mem_data,
  output logic [REG_ADDR_WIDTH-1:0] rdOut,
  output logic                      regWriteEnable,
  output logic [DATA_WIDTH-1:0]     writeBackData,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
  output logic                      rs_hit,
  output logic                      rt_hit,
  output logic [DATA_WIDTH-1:0]     rs_fwd_data,
  output logic [DATA_WIDTH-1:0]     rt_fwd_data
);

  logic [CONTROL_REG_SIZE-1:0] ctrl;
  logic                        commit;
  logic [DATA_WIDTH-1:0]       load_data;
  logic [DATA_WIDTH-1:0]       result;

  logic                      we_q,   we_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,   rd_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;

  logic [HISTORY_DEPTH-1:0]  hist_valid_q, hist_valid_d;
  logic [REG_ADDR_WIDTH-1:0] hist_rd_q    [HISTORY_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] hist_rd_d    [HISTORY_DEPTH];
  logic [DATA_WIDTH-1:0]     hist_data_q  [HISTORY_DEPTH];
  logic [DATA_WIDTH-1:0]     hist_data_d  [HISTORY_DEPTH];

  always_comb begin
    ctrl                                = '0;
    ctrl[CTRL_VALID]                    = in_valid;
    ctrl[CTRL_REG_WRITE]                = in_reg_write;
    ctrl[CTRL_MEM_TO_REG]               = in_mem_to_reg;
    ctrl[CTRL_LOAD_UNSIGNED]            = in_load_unsigned;
    ctrl[CTRL_SIZE_LSB +: 2]            = in_load_size;
  end

  assign commit = ctrl[CTRL_VALID] & ctrl[CTRL_REG_WRITE] & (in_rd != '0) & ~hold;

  load_aligner #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_aligner (
    .mem_data      (in_mem_data),
    .load_size     (ctrl[CTRL_SIZE_LSB +: 2]),
    .load_unsigned (ctrl[CTRL_LOAD_UNSIGNED]),
    .byte_offset   (in_byte_offset),
    .ext_data      (load_data)
  );

  assign result = ctrl[CTRL_MEM_TO_REG] ? load_data : in_alu_data;

  // Write port: strobe drops on idle cycles but address/data are kept.
  always_comb begin
    we_d   = we_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (!hold) begin
      we_d = commit;
      if (commit) begin
        rd_d   = in_rd;
        data_d = result;
      end
    end
  end

  // History ages every unheld cycle; entry 0 mirrors the write port.
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_rd_d    = hist_rd_q;
    hist_data_d  = hist_data_q;
    if (!hold) begin
      for (int i = HISTORY_DEPTH-1; i > 0; i--) begin
        hist_valid_d[i] = hist_valid_q[i-1];
        hist_rd_d[i]    = hist_rd_q[i-1];
        hist_data_d[i]  = hist_data_q[i-1];
      end
      hist_valid_d[0] = commit;
      if (commit) begin
        hist_rd_d[0]   = in_rd;
        hist_data_d[0] = result;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q         <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      hist_valid_q <= '0;
      hist_rd_q    <= '{default: '0};
      hist_data_q  <= '{default: '0};
    end else begin
      we_q         <= we_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      hist_valid_q <= hist_valid_d;
      hist_rd_q    <= hist_rd_d;
      hist_data_q  <= hist_data_d;
    end
  end

  assign regWriteEnable = we_q;
  assign rdOut          = rd_q;
  assign writeBackData  = data_q;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    rs_hit      = 1'b0;
    rs_fwd_data = '0;
    rt_hit      = 1'b0;
    rt_fwd_data = '0;
    for (int i = HISTORY_DEPTH-1; i >= 0; i--) begin
      if (hist_valid_q[i] && (hist_rd_q[i] == rs_addr) && (rs_addr != '0)) begin
        rs_hit      = 1'b1;
        rs_fwd_data = hist_data_q[i];
      end
      if (hist_valid_q[i] && (hist_rd_q[i] == rt_addr) && (rt_addr != '0)) begin
        rt_hit      = 1'b1;
        rt_fwd_data = hist_data_q[i];
      end
    end
  end

endmodule

// File: tb/tb_writeback_bypass.sv
// Directed bench for writeback_bypass: a vector table for single-cycle
// results plus hand-written history, hold and reset sequences.
module tb_writeback_bypass;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [31:0] MEMW = 32'h80FF_7F01;

  logic          clock = 1'b0;
  logic          reset, hold, in_valid, in_reg_write, in_mem_to_reg, in_load_unsigned;
  logic [1:0]    in_load_size, in_byte_offset;
  logic [AW-1:0] in_rd, rdOut, rs_addr, rt_addr;
  logic [DW-1:0] in_alu_data, in_mem_data, writeBackData, rs_fwd_data, rt_fwd_data;
  logic          regWriteEnable, rs_hit, rt_hit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  writeback_bypass #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .HISTORY_DEPTH  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .hold             (hold),
    .in_valid         (in_valid),
    .in_reg_write     (in_reg_write),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .in_byte_offset   (in_byte_offset),
    .in_rd            (in_rd),
    .in_alu_data      (in_alu_data),
    .in_mem_data      (in_mem_data),
    .rdOut            (rdOut),
    .regWriteEnable   (regWriteEnable),
    .writeBackData    (writeBackData),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .rs_hit           (rs_hit),
    .rt_hit           (rt_hit),
    .rs_fwd_data      (rs_fwd_data),
    .rt_fwd_data      (rt_fwd_data)
  );

  typedef struct {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Reference history for the table phase (depth 2, index 0 youngest).
  logic        m_v  [2];
  logic [4:0]  m_rd [2];
  logic [31:0] m_d  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    in_valid         = 1'b0;
    in_reg_write     = 1'b0;
    in_mem_to_reg    = 1'b0;
    in_load_size     = 2'b00;
    in_load_unsigned = 1'b0;
    in_byte_offset   = 2'b00;
    in_rd            = '0;
    in_alu_data      = '0;
    in_mem_data      = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    drive_idle();
    in_valid     = 1'b1;
    in_reg_write = 1'b1;
    in_rd        = rd;
    in_alu_data  = d;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    check({tag, ".we"},   32'(regWriteEnable), 32'(we));
    check({tag, ".rd"},   32'(rdOut),          32'(rd));
    check({tag, ".data"}, writeBackData,       d);
  endtask

  task automatic check_rs(input string tag, input logic h, input logic [31:0] d);
    check({tag, ".rs_hit"}, 32'(rs_hit), 32'(h));
    check({tag, ".rs_fwd"}, rs_fwd_data, d);
  endtask

  task automatic check_rt(input string tag, input logic h, input logic [31:0] d);
    check({tag, ".rt_hit"}, 32'(rt_hit), 32'(h));
    check({tag, ".rt_fwd"}, rt_fwd_data, d);
  endtask

  function automatic void m_look(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 1; i >= 0; i--) begin
      if (m_v[i] && m_rd[i] == a && a != 5'd0) begin
        h = 1'b1;
        d = m_d[i];
      end
    end
  endfunction

  initial begin
    vec_t        v;
    logic        cm, eh;
    logic [31:0] ed;
    logic [4:0]  prev_rd;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd8,  32'h64,        32'h0,        1'b1, 5'd8,  32'h0000_0064};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd9,  32'h0,         MEMW,         1'b1, 5'd9,  32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 5'd10, 32'h0,         MEMW,         1'b1, 5'd10, 32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 5'd11, 32'h0,         MEMW,         1'b1, 5'd11, 32'h0000_007F};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 5'd12, 32'h0,         MEMW,         1'b1, 5'd12, 32'h0000_7F01};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 5'd13, 32'h0,         MEMW,         1'b1, 5'd13, 32'hFFFF_80FF};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 5'd14, 32'h0,         MEMW,         1'b1, 5'd14, 32'h0000_80FF};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd1, 5'd15, 32'h0,         MEMW,         1'b1, 5'd15, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 5'd16, 32'h0,         MEMW,         1'b1, 5'd16, 32'h0000_0001};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 5'd17, 32'h0,         MEMW,         1'b1, 5'd17, 32'h80FF_7F01};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 5'd18, 32'h1234_5678, MEMW,         1'b1, 5'd18, 32'h1234_5678};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  32'h55,        32'h0,        1'b0, 5'd18, 32'h1234_5678};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd7,  32'h99,        32'h0,        1'b0, 5'd18, 32'h1234_5678};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd7,  32'h99,        32'h0,        1'b0, 5'd18, 32'h1234_5678};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd3, 5'd19, 32'h0,         32'h0000_00F0, 1'b1, 5'd19, 32'hFFFF_FFF0};

    // reset state
    reset   = 1'b1;
    hold    = 1'b0;
    rs_addr = 5'd8;
    rt_addr = 5'd0;
    drive_alu(5'd3, 32'hDEAD_BEEF);
    tick();
    tick();
    check_port("reset", 1'b0, 5'd0, 32'h0);
    check_rs("reset", 1'b0, 32'h0);
    check_rt("reset", 1'b0, 32'h0);

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_v[i]  = 1'b0;
      m_rd[i] = '0;
      m_d[i]  = '0;
    end
    prev_rd = 5'd0;

    for (int i = 0; i < NV; i++) begin
      v                = vecs[i];
      in_valid         = v.valid;
      in_reg_write     = v.rw;
      in_mem_to_reg    = v.m2r;
      in_load_size     = v.size;
      in_load_unsigned = v.uns;
      in_byte_offset   = v.off;
      in_rd            = v.rd;
      in_alu_data      = v.alu;
      in_mem_data      = v.mem;
      rs_addr          = v.rd;
      rt_addr          = prev_rd;
      tick();
      cm      = v.valid && v.rw && (v.rd != 5'd0);
      m_v[1]  = m_v[0];
      m_rd[1] = m_rd[0];
      m_d[1]  = m_d[0];
      m_v[0]  = cm;
      m_rd[0] = v.rd;
      m_d[0]  = v.exp_data;
      check_port($sformatf("vec%0d", i), v.exp_we, v.exp_rd, v.exp_data);
      m_look(v.rd, eh, ed);
      check_rs($sformatf("vec%0d", i), eh, ed);
      m_look(prev_rd, eh, ed);
      check_rt($sformatf("vec%0d", i), eh, ed);
      prev_rd = v.rd;
    end

    // history ordering: r5=1, r5=2, then two idle cycles
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    drive_alu(5'd5, 32'd1);
    tick();
    check_rs("hist_c1", 1'b1, 32'd1);
    drive_alu(5'd5, 32'd2);
    tick();
    check_rs("hist_c2", 1'b1, 32'd2);
    check_rt("hist_c2", 1'b1, 32'd2);
    drive_idle();
    tick();
    check_port("hist_idle1", 1'b0, 5'd5, 32'd2);
    check_rs("hist_idle1", 1'b1, 32'd2);
    tick();
    check_rs("hist_idle2", 1'b0, 32'd0);

    // hold: frozen for 3 cycles while a competing commit is presented
    rs_addr = 5'd6;
    rt_addr = 5'd7;
    drive_alu(5'd6, 32'h0000_ABCD);
    tick();
    check_port("hold_c", 1'b1, 5'd6, 32'h0000_ABCD);
    hold = 1'b1;
    drive_alu(5'd7, 32'h0000_7777);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_port($sformatf("hold%0d", k), 1'b1, 5'd6, 32'h0000_ABCD);
      check_rs($sformatf("hold%0d", k), 1'b1, 32'h0000_ABCD);
      check_rt($sformatf("hold%0d", k), 1'b0, 32'h0);
    end
    hold = 1'b0;
    drive_idle();
    tick();
    check_port("unhold1", 1'b0, 5'd6, 32'h0000_ABCD);
    check_rs("unhold1", 1'b1, 32'h0000_ABCD);
    tick();
    check_rs("unhold2", 1'b0, 32'h0);

    // reset mid-stream with valid and hold both set
    rs_addr = 5'd9;
    rt_addr = 5'd10;
    drive_alu(5'd9, 32'h0000_0099);
    tick();
    check_rs("pre_rst", 1'b1, 32'h0000_0099);
    reset = 1'b1;
    hold  = 1'b1;
    drive_alu(5'd10, 32'h0000_0100);
    tick();
    check_port("mid_rst", 1'b0, 5'd0, 32'h0);
    check_rs("mid_rst", 1'b0, 32'h0);
    check_rt("mid_rst", 1'b0, 32'h0);
    reset = 1'b0;
    hold  = 1'b0;
    drive_idle();
    tick();
    check_port("post_rst", 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
